// File: rtl/ysyx_220053_div_seq_if.sv
// Request/result bundle between the execute unit and the sequential divider.
interface ysyx_220053_div_seq_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_signed;
  logic            div_word;
  logic            div_rem;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, dividend, divisor,
    output div_signed, div_word, div_rem, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, dividend, divisor,
    input  div_signed, div_word, div_rem, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_220053_div_seq.sv
// Radix-2 restoring divider for RV64M DIV/REM and W variants.
// Define YSYX_220053_DIV_FASTPATH_EN to bypass CALC on trivial operands.
module ysyx_220053_div_seq #(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_220053_div_seq_if.slave  io
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            fix_ph;
  logic [XLEN-1:0] quo, rem, dmag, a_ext;
  logic            q_neg, r_neg, op_word, op_rem, dz, ov;
  logic [XLEN-1:0] res;

  logic [XLEN-1:0] a_in, b_in, a_mag, b_mag;
  logic            a_neg, b_neg, in_dz, in_ov;
  logic            accept, fast;
  logic [XLEN:0]   sh;
  logic            ge;
  logic [XLEN-1:0] dlo, pick, fin;

  always_comb begin
    if (io.div_word) begin
      a_in = {{HW{io.div_signed & io.dividend[HW-1]}},
              io.dividend[HW-1:0]};
      b_in = {{HW{io.div_signed & io.divisor[HW-1]}},
              io.divisor[HW-1:0]};
    end else begin
      a_in = io.dividend;
      b_in = io.divisor;
    end
    a_neg = io.div_signed & a_in[XLEN-1];
    b_neg = io.div_signed & b_in[XLEN-1];
    a_mag = a_neg ? -a_in : a_in;
    b_mag = b_neg ? -b_in : b_in;
    in_dz = (b_in == '0);
    in_ov = io.div_signed & (b_in == '1) &
            (io.div_word ?
              (a_in == {{(HW+1){1'b1}}, {(HW-1){1'b0}}}) :
              (a_in == {1'b1, {(XLEN-1){1'b0}}}));
`ifdef YSYX_220053_DIV_FASTPATH_EN
    fast = in_dz | in_ov | (a_mag < b_mag);
`else
    fast = 1'b0;
`endif
  end

  assign accept = (state == IDLE) & io.in_valid & ~io.flush;

  // rem < dmag always holds, so a successful trial fits in XLEN bits
  always_comb begin
    sh  = {rem, quo[XLEN-1]};
    ge  = (sh >= {1'b0, dmag});
    dlo = sh[XLEN-1:0] - dmag;
  end

  always_comb begin
    pick = op_rem ? rem : quo;
    if (dz)      pick = op_rem ? a_ext : '1;
    else if (ov) pick = op_rem ? '0 : a_ext;
    fin = op_word ? {{HW{pick[HW-1]}}, pick[HW-1:0]} : pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = fast ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  if (fix_ph) state_nx = DONE;
      DONE: if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (io.flush) state_nx = IDLE;
  end

  // FIX is two cycles: sign restore, then select/extend into result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      fix_ph  <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      dmag    <= '0;
      a_ext   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      op_word <= 1'b0;
      op_rem  <= 1'b0;
      dz      <= 1'b0;
      ov      <= 1'b0;
      res     <= '0;
    end else if (io.flush) begin
      cnt    <= '0;
      fix_ph <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          cnt     <= io.div_word ? CW'(HW) : CW'(XLEN);
          fix_ph  <= 1'b0;
          quo     <= fast ? '0 :
                     (io.div_word ? (a_mag << HW) : a_mag);
          rem     <= fast ? a_mag : '0;
          dmag    <= b_mag;
          a_ext   <= a_in;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          op_word <= io.div_word;
          op_rem  <= io.div_rem;
          dz      <= in_dz;
          ov      <= in_ov;
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          quo <= {quo[XLEN-2:0], ge};
          rem <= ge ? dlo : sh[XLEN-1:0];
        end
        FIX: begin
          if (!fix_ph) begin
            quo    <= q_neg ? -quo : quo;
            rem    <= r_neg ? -rem : rem;
            fix_ph <= 1'b1;
          end else begin
            res    <= fin;
            fix_ph <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state == CALC) | (state == DONE);
  assign io.result    = res;
endmodule

// File: tb/tb_ysyx_220053_div_seq.sv
// Directed self-checking bench for ysyx_220053_div_seq.
module tb_ysyx_220053_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef YSYX_220053_DIV_FASTPATH_EN
  localparam int SP64 = 2;
  localparam int SP32 = 2;
`else
  localparam int SP64 = 66;
  localparam int SP32 = 34;
`endif
  localparam int L64 = 66;
  localparam int L32 = 34;

  ysyx_220053_div_seq_if #(.XLEN(64)) bus ();

  ysyx_220053_div_seq #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w, input logic r);
    @(negedge clk);
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_signed = s;
    bus.div_word   = w;
    bus.div_rem    = r;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("accept_ready_low", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 0;
    while (n < 200 && bus.out_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic finish_op(input string tag, input logic [63:0] exp,
                           input int lat);
    wait_valid(tag, lat);
    check({tag, "_res"}, bus.result, exp);
    @(posedge clk);
    #1;
    check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.div_signed = 1'b0;
    bus.div_word   = 1'b0;
    bus.div_rem    = 1'b0;
    bus.out_ready  = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    start(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    finish_op("divu", 64'd14, L64);
    start(64'd100, 64'd7, 1'b0, 1'b0, 1'b1);
    finish_op("remu", 64'd2, L64);

    start(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b0);
    finish_op("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, L64);
    start(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b1);
    finish_op("rem_neg", 64'hFFFF_FFFF_FFFF_FFFF, L64);

    start(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    finish_op("divu_z", 64'hFFFF_FFFF_FFFF_FFFF, SP64);
    start(64'h0000_0000_8000_0000, 64'd0, 1'b1, 1'b1, 1'b1);
    finish_op("remw_z", 64'hFFFF_FFFF_8000_0000, SP32);

    start(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          1'b1, 1'b1, 1'b0);
    finish_op("divw_ov", 64'hFFFF_FFFF_8000_0000, SP32);
    start(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          1'b1, 1'b1, 1'b1);
    finish_op("remw_ov", 64'd0, SP32);
    start(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          1'b1, 1'b0, 1'b0);
    finish_op("div_ov", 64'h8000_0000_0000_0000, SP64);

    // back-pressure: DIVUW with garbage upper bits, bit 31 set in result
    bus.out_ready = 1'b0;
    start(64'h1234_5678_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0);
    wait_valid("bp", L32);
    @(negedge clk);
    bus.dividend   = 64'd100;
    bus.divisor    = 64'd7;
    bus.div_signed = 1'b0;
    bus.div_word   = 1'b0;
    bus.div_rem    = 1'b1;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp2_accepted", 64'(bus.in_ready), 64'd0);
    finish_op("bp2", 64'd2, L64);

    start(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    start(64'h0000_0000_FFFF_FFFF, 64'h10, 1'b0, 1'b1, 1'b0);
    finish_op("divuw", 64'h0000_0000_0FFF_FFFF, L32);

    start(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("calc_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start(64'd100, 64'd7, 1'b0, 1'b0, 1'b1);
    finish_op("post_rst", 64'd2, L64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
